// File: rtl/clk_divider_bank_if.sv
// clk_divider_bank_if: valid/ready reconfiguration channel for clk_divider_bank.
interface clk_divider_bank_if #(
  parameter int NUM_CLOCKS = 4,
  parameter int DIV_WIDTH = 8
);
  localparam int CW = NUM_CLOCKS > 1 ? $clog2(NUM_CLOCKS) : 1;
  logic cfg_valid;
  logic cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] cfg_phase;
  modport master (output cfg_valid, cfg_chan, cfg_div, cfg_phase, input cfg_ready);
  modport slave (input cfg_valid, cfg_chan, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clk_divider_bank.sv
// clk_divider_bank: bank of integer clock dividers restarted together on each reconfiguration.
// Per-channel phase offsets are built only when CLK_DIVIDER_BANK_PHASE_EN is defined.
module clk_divider_bank #(
  parameter int NUM_CLOCKS = 4,
  parameter int DIV_WIDTH = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 4
) (
  input logic refclk,
  input logic rst,
  clk_divider_bank_if.slave cfg,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic locked
);
  localparam int LW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  typedef enum logic [1:0] {LOCKING, LOCKED, RELOAD} state_t;
  state_t state, state_nx;
  logic [LW-1:0] lock_cnt;
  logic lock_done;
  logic hs_ok;
  assign lock_done = lock_cnt == LW'(LOCK_CYCLES - 1);
  assign hs_ok = cfg.cfg_valid && cfg.cfg_ready && 32'(cfg.cfg_chan) < NUM_CLOCKS;
  assign cfg.cfg_ready = locked;
  always_comb begin
    state_nx = state;
    if (state == RELOAD) state_nx = LOCKING;
    else if (state == LOCKED && hs_ok) state_nx = RELOAD;
    else if (state == LOCKING && lock_done) state_nx = LOCKED;
  end
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state <= LOCKING;
      locked <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state <= state_nx;
      locked <= state_nx == LOCKED;
      lock_cnt <= state == RELOAD ? '0 : state == LOCKING && !lock_done ? lock_cnt + LW'(1) : lock_cnt;
    end
  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] div, e, half, ph, cur, cnt;
    logic sel, clk_q;
    assign sel = hs_ok && 32'(cfg.cfg_chan) == i;
    assign e = div < DIV_WIDTH'(2) ? DIV_WIDTH'(2) : div;
    assign half = (e >> 1) + DIV_WIDTH'(e[0]);
    // RELOAD substitutes the phase for the count so every channel restarts on the same edge
    assign cur = state == RELOAD ? ph : cnt;
    assign outclk[i] = clk_q;
    always_ff @(posedge refclk or posedge rst)
      if (rst) div <= DIV_WIDTH'(DEFAULT_DIV);
      else if (sel) div <= cfg.cfg_div;
    always_ff @(posedge refclk or posedge rst)
      if (rst) begin
        cnt <= '0;
        clk_q <= 1'b0;
      end else begin
        cnt <= cur >= e - DIV_WIDTH'(1) ? '0 : cur + DIV_WIDTH'(1);
        clk_q <= !hs_ok && cur < half;
      end
`ifdef CLK_DIVIDER_BANK_PHASE_EN
    logic [DIV_WIDTH-1:0] phase;
    always_ff @(posedge refclk or posedge rst)
      if (rst) phase <= '0;
      else if (sel) phase <= cfg.cfg_phase;
    assign ph = phase < e ? phase : '0;
`else
    assign ph = '0;
`endif
  end
`ifndef CLK_DIVIDER_BANK_PHASE_EN
  logic unused_phase;
  assign unused_phase = ^cfg.cfg_phase;
`endif
endmodule

// File: doc/clk_divider_bank.md
CLK_DIVIDER_BANK -- requirements
Module: clk_divider_bank

Interface
REQ-001 The module SHALL provide parameter NUM_CLOCKS, default 4, number of output clock channels (1..16).
REQ-002 The module SHALL provide parameter DIV_WIDTH, default 8, width of the per-channel divide and phase fields.
REQ-003 The module SHALL provide parameter LOCK_CYCLES, default 16, refclk cycles from (re)start to locked assertion (>=1).
REQ-004 The module SHALL provide parameter DEFAULT_DIV, default 4, divide ratio loaded into every channel at reset.
REQ-005 The module SHALL provide port refclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL provide port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-007 The module SHALL provide port cfg_valid, input, 1 bit, reconfiguration request valid.
REQ-008 The module SHALL provide port cfg_ready, output, 1 bit, block can accept a reconfiguration.
REQ-009 The module SHALL provide port cfg_chan, input, max(1,clog2(NUM_CLOCKS)) bits, target channel index.
REQ-010 The module SHALL provide port cfg_div, input, DIV_WIDTH bits, new divide ratio.
REQ-011 The module SHALL provide port cfg_phase, input, DIV_WIDTH bits, new phase offset in refclk cycles.
REQ-012 The module SHALL provide port outclk, output, NUM_CLOCKS bits, registered divided clocks, one per channel.
REQ-013 The module SHALL provide port locked, output, 1 bit, all outputs running with committed settings.

Function
REQ-014 Each channel SHALL use an effective divide E = max(div, 2); div values 0 and 1 are treated as 2.
REQ-015 Each channel counter SHALL count 0..E-1 and wrap to 0; outclk[i] is registered high while count < ceil(E/2), otherwise low.
REQ-016 Odd E SHALL give a high phase one cycle longer than the low phase (E=3: 2 high, 1 low).
REQ-017 The FSM SHALL have three states: LOCKING, LOCKED and RELOAD.
REQ-018 LOCKING: the lock counter increments each cycle; on reaching LOCK_CYCLES-1 the FSM goes to LOCKED on the next edge.
REQ-019 locked SHALL be a registered output equal to (state==LOCKED); cfg_ready SHALL be a registered output equal to (state==LOCKED).
REQ-020 A handshake SHALL occur only when cfg_valid and cfg_ready are both high at a rising edge; cfg_valid while not ready is ignored, not queued.
REQ-021 On a handshake with cfg_chan < NUM_CLOCKS, div and phase for that channel SHALL be committed, the FSM goes to RELOAD, and locked and cfg_ready fall on that same edge.
REQ-022 On a handshake with cfg_chan >= NUM_CLOCKS, the request SHALL be dropped; state, locked and cfg_ready are unchanged.
REQ-023 RELOAD SHALL last exactly one cycle: all outclk bits are driven 0, every channel counter is loaded with its phase (or 0 if phase >= E), and the lock counter is cleared; the FSM then goes to LOCKING.
REQ-024 All channels SHALL restart together after RELOAD so that their phase relationships are deterministic.
REQ-025 Counters SHALL keep running in LOCKING and LOCKED; only RELOAD and reset disturb them.
REQ-026 Asserting rst during any state, including RELOAD, SHALL abort immediately and discard pending settings.

Reset
REQ-027 While rst is high: outclk=0, locked=0, cfg_ready=0, all div=DEFAULT_DIV, all phase=0, all counters=0, lock counter=0, state=LOCKING.
REQ-028 After rst is released, locked SHALL rise at the LOCK_CYCLES-th rising edge of refclk.

Configuration
REQ-029 With macro CLK_DIVIDER_BANK_PHASE_EN defined, cfg_phase SHALL be stored and applied in RELOAD per REQ-023.
REQ-030 Without CLK_DIVIDER_BANK_PHASE_EN, cfg_phase SHALL be ignored, no phase storage SHALL be built, and every counter reloads to 0.

Verification
REQ-031 The bench SHALL cover: defaults, rst release -> locked=1 at edge 16, all outclk toggle 2 high/2 low, in phase.
REQ-032 The bench SHALL cover: cfg chan=1 div=5 phase=0 -> 1 RELOAD cycle with outclk=0, locked low 17 cycles, outclk[1] 3 high/2 low.
REQ-033 The bench SHALL cover (PHASE_EN): chan=2 div=4 phase=2 -> outclk[2] is outclk[0] inverted after RELOAD; without PHASE_EN it matches outclk[0].
REQ-034 The bench SHALL cover: cfg_div=0 and 1 -> channel behaves as div=2; cfg_phase=9 with div=4 -> phase treated as 0.
REQ-035 The bench SHALL cover: cfg_chan=7 with NUM_CLOCKS=4 -> request dropped, locked stays 1; cfg_valid during LOCKING -> no effect.
REQ-036 The bench SHALL cover: rst asserted mid-RELOAD -> outputs reset immediately, and after release the defaults apply with relock at 16 cycles.
